// File: rtl/cpu_regfile_xfer_pkg.sv
// Shared types for the register file and its bulk-transfer sequencer.
// Holds op encodings, FSM states and the default flag register index.
package cpu_regfile_xfer_pkg;

    typedef enum logic [1:0] {
        XFER_STORE   = 2'd0,
        XFER_LOAD    = 2'd1,
        XFER_SAVE    = 2'd2,
        XFER_RESTORE = 2'd3
    } xfer_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD_ISSUE,
        S_LOAD_DRAIN,
        S_RPL_SAVE,
        S_RPL_RESTORE,
        S_DONE
    } xfer_state_t;

    localparam int FLAG_REG_DEF = 15;

endpackage

// File: rtl/cpu_rd_delay.sv
// Valid+index shift line matching the RAM read latency.
// Its output marks which register the current mem_rdata belongs to.
module cpu_rd_delay #(
    parameter int LAT = 2,
    parameter int IW  = 4
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          in_vld,
    input  logic [IW-1:0] in_idx,
    output logic          out_vld,
    output logic [IW-1:0] out_idx,
    output logic          pend
);

    // all stages except the output one; empty means drain is finished
    localparam logic [LAT-1:0] MASK = LAT'((1 << (LAT - 1)) - 1);

    logic [LAT-1:0] vld;
    logic [IW-1:0]  idx [LAT];

    // shift one stage per clock
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) idx[i] <= '0;
        end else begin
            vld[0] <= in_vld;
            idx[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_vld = vld[LAT-1];
    assign out_idx = idx[LAT-1];
    assign pend    = |(vld & MASK);

endmodule

// File: rtl/cpu_regfile_xfer.sv
// V register file with a bulk-transfer sequencer for RAM and RPL.
// One register moves per cycle; the CPU issues start and waits for done.
module cpu_regfile_xfer
    import cpu_regfile_xfer_pkg::*;
#(
    parameter int NREGS     = 16,
    parameter int DW        = 8,
    parameter int AW        = 12,
    parameter int FLAG_REG  = FLAG_REG_DEF,
    parameter int RPL_DEPTH = 8,
    parameter int RD_LAT    = 2,
    localparam int IW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic [IW-1:0] ra_idx,
    output logic [DW-1:0] ra_data,
    input  logic [IW-1:0] rb_idx,
    output logic [DW-1:0] rb_data,
    input  logic          wa_en,
    input  logic [IW-1:0] wa_idx,
    input  logic [DW-1:0] wa_data,
    input  logic          wf_en,
    input  logic [DW-1:0] wf_data,
    input  logic          xfer_start,
    input  logic [1:0]    xfer_op,
    input  logic [IW-1:0] xfer_last,
    input  logic [AW-1:0] xfer_addr,
    output logic          xfer_busy,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int RW = (RPL_DEPTH > 1) ? $clog2(RPL_DEPTH) : 1;
    localparam logic [IW-1:0] FIDX = IW'(FLAG_REG);

    xfer_state_t   state;
    logic [IW-1:0] k;
    logic [IW-1:0] k_inc;
    logic [IW-1:0] last_q;
    logic [AW-1:0] addr_q;
    logic [RW-1:0] rk;
    logic          rpl_bad;
    logic          cap_vld;
    logic [IW-1:0] cap_idx;
    logic          dly_pend;

    logic [DW-1:0] v   [NREGS];
    logic [DW-1:0] rpl [RPL_DEPTH];

    assign k_inc     = k + IW'(1);
    assign rk        = RW'(k);
    assign rpl_bad   = {1'b0, xfer_last} >= (IW+1)'(RPL_DEPTH);
    assign xfer_busy = (state != S_IDLE);
    assign ra_data   = v[ra_idx];
    assign rb_data   = v[rb_idx];

    cpu_rd_delay #(
        .LAT (RD_LAT),
        .IW  (IW)
    ) u_rd_delay (
        .clk     (clk),
        .res_n   (res_n),
        .in_vld  (state == S_LOAD_ISSUE),
        .in_idx  (k),
        .out_vld (cap_vld),
        .out_idx (cap_idx),
        .pend    (dly_pend)
    );

    // sequencer FSM; memory strobes are registered alongside the state
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= S_IDLE;
            k         <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (xfer_start) begin
                        last_q <= xfer_last;
                        addr_q <= xfer_addr;
                        k      <= '0;
                        unique case (xfer_op_t'(xfer_op))
                            XFER_STORE: begin
                                state     <= S_STORE;
                                mem_en    <= 1'b1;
                                mem_wr    <= 1'b1;
                                mem_addr  <= xfer_addr;
                                mem_wdata <= v[0];
                            end
                            XFER_LOAD: begin
                                state    <= S_LOAD_ISSUE;
                                mem_en   <= 1'b1;
                                mem_wr   <= 1'b0;
                                mem_addr <= xfer_addr;
                            end
                            XFER_SAVE: begin
                                if (rpl_bad) xfer_err <= 1'b1;
                                else         state    <= S_RPL_SAVE;
                            end
                            XFER_RESTORE: begin
                                if (rpl_bad) xfer_err <= 1'b1;
                                else         state    <= S_RPL_RESTORE;
                            end
                        endcase
                    end
                end
                S_STORE: begin
                    if (k == last_q) begin
                        state     <= S_DONE;
                        xfer_done <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_wr    <= 1'b0;
                    end else begin
                        k         <= k_inc;
                        mem_addr  <= addr_q + AW'(k_inc);
                        mem_wdata <= v[k_inc];
                    end
                end
                S_LOAD_ISSUE: begin
                    if (k == last_q) begin
                        state  <= S_LOAD_DRAIN;
                        mem_en <= 1'b0;
                    end else begin
                        k        <= k_inc;
                        mem_addr <= addr_q + AW'(k_inc);
                    end
                end
                S_LOAD_DRAIN: begin
                    if (!dly_pend) begin
                        state     <= S_DONE;
                        xfer_done <= 1'b1;
                    end
                end
                S_RPL_SAVE, S_RPL_RESTORE: begin
                    if (k == last_q) begin
                        state     <= S_DONE;
                        xfer_done <= 1'b1;
                    end else begin
                        k <= k_inc;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // V writes: sequencer owns the file while busy, else wa then wf
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < NREGS; i++) v[i] <= '0;
        end else if (xfer_busy) begin
            if (cap_vld) v[cap_idx] <= mem_rdata;
            if (state == S_RPL_RESTORE) v[k] <= rpl[rk];
        end else begin
            if (wa_en) v[wa_idx] <= wa_data;
            if (wf_en) v[FIDX] <= wf_data;
        end
    end

    // RPL flag store, filled one entry per cycle during SAVE
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < RPL_DEPTH; i++) rpl[i] <= '0;
        end else if (state == S_RPL_SAVE) begin
            rpl[rk] <= v[k];
        end
    end

endmodule

// File: tb/tb_cpu_regfile_xfer.sv
// Directed bench for cpu_regfile_xfer with a RD_LAT=2 RAM model.
// Expected values are hand-computed constants.
module tb_cpu_regfile_xfer;

    logic        clk = 1'b0;
    logic        res_n;
    logic [3:0]  ra_idx, rb_idx, wa_idx, xfer_last;
    logic [7:0]  ra_data, rb_data, wa_data, wf_data;
    logic        wa_en, wf_en, xfer_start;
    logic [1:0]  xfer_op;
    logic [11:0] xfer_addr, mem_addr;
    logic        xfer_busy, xfer_done, xfer_err;
    logic        mem_en, mem_wr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [11:0] wl_a [64];
    logic [7:0]  wl_d [64];
    int          wl_n = 0;
    logic [7:0]  rd_s1, rd_s2;
    int          lat;
    int          base;

    cpu_regfile_xfer dut (
        .clk        (clk),
        .res_n      (res_n),
        .ra_idx     (ra_idx),
        .ra_data    (ra_data),
        .rb_idx     (rb_idx),
        .rb_data    (rb_data),
        .wa_en      (wa_en),
        .wa_idx     (wa_idx),
        .wa_data    (wa_data),
        .wf_en      (wf_en),
        .wf_data    (wf_data),
        .xfer_start (xfer_start),
        .xfer_op    (xfer_op),
        .xfer_last  (xfer_last),
        .xfer_addr  (xfer_addr),
        .xfer_busy  (xfer_busy),
        .xfer_done  (xfer_done),
        .xfer_err   (xfer_err),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [11:0] a);
        if (a >= 12'h300 && a < 12'h310) return 8'hA0 + 8'(a - 12'h300);
        return a[7:0] ^ 8'h5A;
    endfunction

    // two-stage read pipeline plus a log of every write strobe
    always @(posedge clk) begin
        rd_s1 <= ram_rd(mem_addr);
        rd_s2 <= rd_s1;
        if (mem_en && mem_wr) begin
            wl_a[wl_n % 64] <= mem_addr;
            wl_d[wl_n % 64] <= mem_wdata;
            wl_n <= wl_n + 1;
        end
    end
    assign mem_rdata = rd_s2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] i, input logic [7:0] d);
        wa_en = 1'b1; wa_idx = i; wa_data = d;
        tick();
        wa_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] i, output logic [7:0] d);
        ra_idx = i;
        #1;
        d = ra_data;
    endtask

    // start an op and count cycles until done; optional dropped write at cycle pulse_at
    task automatic run(input logic [1:0] op, input logic [3:0] last,
                       input logic [11:0] addr, input int pulse_at,
                       output int c);
        xfer_op = op; xfer_last = last; xfer_addr = addr; xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        c = 1;
        while (!xfer_done && c < 64) begin
            if (c == pulse_at) begin
                wa_en = 1'b1; wa_idx = 4'd2; wa_data = 8'h77;
            end
            tick();
            wa_en = 1'b0;
            c++;
        end
    endtask

    initial begin
        logic [7:0] d;
        res_n = 1'b0;
        ra_idx = '0; rb_idx = '0; wa_idx = '0; wa_data = '0; wa_en = 1'b0;
        wf_en = 1'b0; wf_data = '0; xfer_start = 1'b0; xfer_op = '0;
        xfer_last = '0; xfer_addr = '0;
        #23;
        chk("rst_busy", xfer_busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_v0", ra_data, 8'h00);
        res_n = 1'b1;
        tick();

        // STORE V0..V3 to 0x200
        wr(0, 8'd11); wr(1, 8'd22); wr(2, 8'd33); wr(3, 8'd44);
        rd(2, d); chk("wa_v2", d, 8'd33);
        base = wl_n;
        rb_idx = 4'd1;
        xfer_op = 2'd0; xfer_last = 4'd3; xfer_addr = 12'h200; xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        chk("store_busy", xfer_busy, 1);
        chk("store_rb_busy", rb_data, 8'd22);
        lat = 1;
        while (!xfer_done && lat < 64) begin tick(); lat++; end
        chk("store_lat", lat, 5);
        tick();
        chk("store_mem_en_after", mem_en, 0);
        chk("store_nwr", wl_n - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("store_addr", wl_a[(base + i) % 64], 12'h200 + i);
            chk("store_data", wl_d[(base + i) % 64], 11 * (i + 1));
        end

        // LOAD 16 regs from 0x300 with a dropped write at cycle 4
        run(2'd1, 4'd15, 12'h300, 4, lat);
        chk("load_lat", lat, 19);
        tick();
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d);
            chk("load_v", d, 8'hA0 + i);
        end

        // SAVE, clear, RESTORE
        run(2'd2, 4'd7, 12'h000, -1, lat);
        chk("save_lat", lat, 9);
        tick();
        for (int i = 0; i < 8; i++) wr(4'(i), 8'h00);
        rd(3, d); chk("cleared_v3", d, 8'h00);
        run(2'd3, 4'd7, 12'h000, -1, lat);
        chk("restore_lat", lat, 9);
        tick();
        for (int i = 0; i < 8; i++) begin
            rd(4'(i), d);
            chk("restore_v", d, 8'hA0 + i);
        end

        // rejected SAVE must not touch RPL
        wr(0, 8'h99);
        xfer_op = 2'd2; xfer_last = 4'd8; xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        chk("err_pulse", xfer_err, 1);
        chk("err_busy", xfer_busy, 0);
        tick();
        chk("err_one_cycle", xfer_err, 0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (xfer_done) lat++;
            tick();
        end
        chk("err_no_done", lat, 0);
        wr(1, 8'h42);
        run(2'd3, 4'd0, 12'h000, -1, lat);
        chk("restore0_lat", lat, 2);
        tick();
        rd(0, d); chk("rpl_unchanged_v0", d, 8'hA0);
        rd(1, d); chk("last0_v1_kept", d, 8'h42);

        // flag write priority
        wa_en = 1'b1; wa_idx = 4'd15; wa_data = 8'h55;
        wf_en = 1'b1; wf_data = 8'h01;
        tick();
        rd(15, d); chk("wf_wins", d, 8'h01);
        wr(15, 8'h00);
        wa_en = 1'b1; wa_idx = 4'd3; wa_data = 8'h55;
        wf_en = 1'b1; wf_data = 8'h01;
        tick();
        wa_en = 1'b0; wf_en = 1'b0;
        rd(3, d);  chk("wa_v3", d, 8'h55);
        rd(15, d); chk("wf_vf", d, 8'h01);

        // address wrap
        base = wl_n;
        run(2'd0, 4'd2, 12'hFFF, -1, lat);
        chk("wrap_lat", lat, 4);
        tick();
        chk("wrap_a0", wl_a[(base + 0) % 64], 12'hFFF);
        chk("wrap_a1", wl_a[(base + 1) % 64], 12'h000);
        chk("wrap_a2", wl_a[(base + 2) % 64], 12'h001);

        // asynchronous reset in LOAD cycle 3
        xfer_op = 2'd1; xfer_last = 4'd15; xfer_addr = 12'h300; xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        tick(); tick();
        chk("rst_pre_mem_en", mem_en, 1);
        #2 res_n = 1'b0;
        #1;
        chk("rst_async_mem_en", mem_en, 0);
        chk("rst_async_mem_wr", mem_wr, 0);
        chk("rst_async_busy", xfer_busy, 0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d);
            chk("rst_v", d, 8'h00);
        end
        #1 res_n = 1'b1;
        tick(); tick();
        chk("post_rst_busy", xfer_busy, 0);
        chk("post_rst_done", xfer_done, 0);
        chk("post_rst_mem_en", mem_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
